// File: rtl/axis_downsizer.sv
// Replays DATA_WIDTH_BYTES-wide AXI-Stream beats as a 1-byte AXI-Stream, lowest byte first.
// Define AXIS_DOWNSIZER_NULL_SKIP_EN to skip null (tkeep=0) bytes instead of emitting them.
module axis_downsizer #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ID_WIDTH         = 1,
    parameter int DEST_WIDTH       = 1,
    parameter int USER_WIDTH       = 1
) (
    input  logic                          clk,
    input  logic                          arst,

    input  logic [8*DATA_WIDTH_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_WIDTH_BYTES-1:0]   s_axis_tkeep,
    input  logic [DATA_WIDTH_BYTES-1:0]   s_axis_tstrb,
    input  logic                          s_axis_tlast,
    input  logic [ID_WIDTH-1:0]           s_axis_tid,
    input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,

    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tkeep,
    output logic                          m_axis_tstrb,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [DEST_WIDTH-1:0]         m_axis_tdest,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);
    localparam int NB = DATA_WIDTH_BYTES;
    localparam int DW = 8 * DATA_WIDTH_BYTES;

    logic                  hold_q, hold_d;
    logic [NB-1:0]         pend_q, pend_d;
    logic [DW-1:0]         data_q, data_d;
    logic [NB-1:0]         keep_q, keep_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic                  last_q, last_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    logic [NB-1:0] sel;
    logic          found;
    logic          final_byte;
    logic          in_hs;
    logic          out_hs;
    logic [NB-1:0] pend_load;
    logic          accept;

`ifdef AXIS_DOWNSIZER_NULL_SKIP_EN
    // An all-null beat only occupies the holding slot when it carries tlast.
    assign pend_load = s_axis_tkeep;
    assign accept    = (|s_axis_tkeep) || s_axis_tlast;
`else
    assign pend_load = '1;
    assign accept    = 1'b1;
`endif

    // Priority encoder: one-hot select of the lowest pending byte.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (pend_q[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // With pend empty (null terminator) the mux yields tdata=0, tkeep=0, tstrb=0.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tstrb = 1'b0;
        m_axis_tkeep = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (sel[i]) begin
                m_axis_tdata = data_q[8*i +: 8];
                m_axis_tstrb = strb_q[i];
                m_axis_tkeep = keep_q[i];
            end
        end
    end

    assign final_byte    = ((pend_q & ~sel) == '0);
    assign m_axis_tvalid = hold_q;
    assign m_axis_tlast  = hold_q && last_q && final_byte;
    assign m_axis_tid    = id_q;
    assign m_axis_tdest  = dest_q;
    assign m_axis_tuser  = user_q;

    assign out_hs        = hold_q && m_axis_tready;
    assign s_axis_tready = !arst && (!hold_q || (out_hs && final_byte));
    assign in_hs         = s_axis_tvalid && s_axis_tready;

    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        if (out_hs) begin
            pend_d = pend_q & ~sel;
            if (final_byte) begin
                hold_d = 1'b0;
            end
        end
        // A capture in the same cycle as the final byte keeps the slot full.
        if (in_hs) begin
            pend_d = pend_load;
            hold_d = accept;
        end
        data_d = in_hs ? s_axis_tdata : data_q;
        keep_d = in_hs ? s_axis_tkeep : keep_q;
        strb_d = in_hs ? s_axis_tstrb : strb_q;
        last_d = in_hs ? s_axis_tlast : last_q;
        id_d   = in_hs ? s_axis_tid   : id_q;
        dest_d = in_hs ? s_axis_tdest : dest_q;
        user_d = in_hs ? s_axis_tuser : user_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold_q <= 1'b0;
            pend_q <= '0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
        end
    end

    // NOTE: the held beat is payload qualified by hold_q, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
        strb_q <= strb_d;
        last_q <= last_d;
        id_q   <= id_d;
        dest_q <= dest_d;
        user_q <= user_d;
    end

endmodule

// File: tb/tb_axis_downsizer.sv
// Directed self-checking bench for axis_downsizer (default 4-byte beats, 1-bit sideband).
module tb_axis_downsizer;
    logic        clk = 1'b0;
    logic        arst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep, s_tstrb;
    logic        s_tlast, s_tvalid, s_tready;
    logic [0:0]  s_tid, s_tdest, s_tuser;
    logic [7:0]  m_tdata;
    logic        m_tkeep, m_tstrb, m_tlast, m_tvalid, m_tready;
    logic [0:0]  m_tid, m_tdest, m_tuser;

    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  exp_side = 3'b000;

    always #5 clk = ~clk;

    axis_downsizer #(
        .DATA_WIDTH_BYTES(4), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)
    ) dut (
        .clk(clk), .arst(arst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tstrb(s_tstrb),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tstrb(m_tstrb),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] st,
                              input logic l, input logic [2:0] side);
        s_tdata  = d;
        s_tkeep  = k;
        s_tstrb  = st;
        s_tlast  = l;
        {s_tid, s_tdest, s_tuser} = side;
        exp_side = side;
        s_tvalid = 1'b1;
    endtask

    // Called at a falling edge: sets m_tready, checks the presented byte, advances one cycle.
    task automatic byte_chk(input string tag, input logic rdy, input logic [7:0] d, input logic k,
                            input logic st, input logic l, input logic sr);
        m_tready = rdy;
        #1;
        check({tag, ".tvalid"}, 32'(m_tvalid), 32'(1'b1));
        check({tag, ".tdata"}, 32'(m_tdata), 32'(d));
        check({tag, ".tkeep"}, 32'(m_tkeep), 32'(k));
        check({tag, ".tstrb"}, 32'(m_tstrb), 32'(st));
        check({tag, ".tlast"}, 32'(m_tlast), 32'(l));
        check({tag, ".side"}, 32'({m_tid, m_tdest, m_tuser}), 32'(exp_side));
        check({tag, ".s_tready"}, 32'(s_tready), 32'(sr));
        @(negedge clk);
    endtask

    task automatic idle_chk(input string tag, input logic sr);
        #1;
        check({tag, ".tvalid"}, 32'(m_tvalid), 32'(1'b0));
        check({tag, ".s_tready"}, 32'(s_tready), 32'(sr));
        @(negedge clk);
    endtask

    initial begin
        arst     = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tstrb  = '0;
        s_tlast  = 1'b0;
        {s_tid, s_tdest, s_tuser} = 3'b000;
        m_tready = 1'b0;

        // Reset state
        @(negedge clk);
        idle_chk("reset", 1'b0);
        arst = 1'b0;
        idle_chk("post_reset", 1'b1);

        // Single beat, lowest byte first, tlast on the top byte
        drive_beat(32'h44332211, 4'hF, 4'hF, 1'b1, 3'b101);
        m_tready = 1'b1;
        #1 check("t1.accept", 32'(s_tready), 32'(1'b1));
        @(negedge clk);
        s_tvalid = 1'b0;
        byte_chk("t1.b0", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t1.b1", 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t1.b2", 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t1.b3", 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_chk("t1.done", 1'b1);

        // Back-to-back beats, second captured while 0xDD is taken
        drive_beat(32'hDDCCBBAA, 4'hF, 4'hF, 1'b0, 3'b010);
        @(negedge clk);
        drive_beat(32'h04030201, 4'hF, 4'hF, 1'b1, 3'b010);
        byte_chk("t2.b0", 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t2.b1", 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t2.b2", 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t2.b3", 1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, 1'b1);
        s_tvalid = 1'b0;
        byte_chk("t2.b4", 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t2.b5", 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t2.b6", 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t2.b7", 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_chk("t2.done", 1'b1);

        // Backpressure: tready 1,0,0,1,... holds each byte stable
        drive_beat(32'h44332211, 4'hF, 4'hF, 1'b1, 3'b111);
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        byte_chk("t3.c0", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c1", 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c2", 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c3", 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c4", 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c5", 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c6", 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t3.c7", 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
        byte_chk("t3.c8", 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
        byte_chk("t3.c9", 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_chk("t3.done", 1'b1);

        // Sparse keep=0x5 with strb=0xA
        drive_beat(32'h44332211, 4'h5, 4'hA, 1'b1, 3'b100);
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
`ifdef AXIS_DOWNSIZER_NULL_SKIP_EN
        byte_chk("t4.b0", 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        byte_chk("t4.b2", 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_chk("t4.done", 1'b1);

        // All-null beat with tlast: one terminator byte
        drive_beat(32'h12345678, 4'h0, 4'h0, 1'b1, 3'b011);
        @(negedge clk);
        s_tvalid = 1'b0;
        byte_chk("t5.term", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_chk("t5.term_done", 1'b1);

        // All-null beat without tlast: dropped, block stays empty
        drive_beat(32'h12345678, 4'h0, 4'h0, 1'b0, 3'b011);
        @(negedge clk);
        s_tvalid = 1'b0;
        idle_chk("t5.drop", 1'b1);
`else
        byte_chk("t4.b0", 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        byte_chk("t4.b1", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        byte_chk("t4.b2", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        byte_chk("t4.b3", 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_chk("t4.done", 1'b1);

        // All-null beat is still emitted byte by byte
        drive_beat(32'h87654321, 4'h0, 4'hF, 1'b0, 3'b011);
        @(negedge clk);
        s_tvalid = 1'b0;
        byte_chk("t5.b0", 1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0);
        byte_chk("t5.b1", 1'b1, 8'h43, 1'b0, 1'b1, 1'b0, 1'b0);
        byte_chk("t5.b2", 1'b1, 8'h65, 1'b0, 1'b1, 1'b0, 1'b0);
        byte_chk("t5.b3", 1'b1, 8'h87, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_chk("t5.done", 1'b1);
`endif

        // Asynchronous reset in the middle of a held beat
        drive_beat(32'h44332211, 4'hF, 4'hF, 1'b1, 3'b001);
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        byte_chk("t6.b0", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t6.b1", 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 arst = 1'b1;
        #1;
        check("t6.rst.tvalid", 32'(m_tvalid), 32'(1'b0));
        check("t6.rst.s_tready", 32'(s_tready), 32'(1'b0));
        #6 arst = 1'b0;
        @(negedge clk);
        idle_chk("t6.no_resume", 1'b1);
        drive_beat(32'hA5A5A5A5, 4'hF, 4'h1, 1'b1, 3'b110);
        @(negedge clk);
        s_tvalid = 1'b0;
        byte_chk("t6.n0", 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        byte_chk("t6.n1", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        byte_chk("t6.n2", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        byte_chk("t6.n3", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        idle_chk("t6.done", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
